// File: rtl/ccff_pkg.sv
// Shared types for the ccff chain loader: FSM encoding, debug view and word-count helper.
package ccff_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } ccff_state_e;

  typedef struct packed {
    ccff_state_e state;
    logic        buf_full;
    logic        bit_avail;
    logic        last_bit;
  } ccff_dbg_t;

  // Number of config words needed to cover a chain of chain_len bits.
  function automatic int ceil_div(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Config-word stream into the loader and readback-word stream out of it.
interface ccff_chain_loader_if #(
  parameter int WORD_W = 8
);
  // cfg: a word transfers on a clock edge where cfg_valid & cfg_ready are both 1;
  // cfg_ready never looks at cfg_valid. rb: rb_valid is a 1-cycle pulse, no backpressure.
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [WORD_W-1:0] rb_data;
  logic              rb_valid;

  modport master (output cfg_data, output cfg_valid, input cfg_ready,
                  input rb_data, input rb_valid);
  modport slave  (input cfg_data, input cfg_valid, output cfg_ready,
                  output rb_data, output rb_valid);
endinterface

// File: rtl/ccff_bit_serializer.sv
// One-word prefetch buffer feeding an MSB-first shift register.
module ccff_bit_serializer #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              word_valid_i,
  input  logic [WORD_W-1:0] word_data_i,
  input  logic              shift_i,
  output logic              buf_full_o,
  output logic              bit_o,
  output logic              bit_avail_o,
  output logic              last_bit_o
);

  localparam int SC_W = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] buf_q, buf_d;
  logic              buf_full_q, buf_full_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [SC_W-1:0]   cnt_q, cnt_d;
  logic              reload;

  always_comb begin
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    sreg_d     = sreg_q;
    cnt_d      = cnt_q;
    reload     = 1'b0;

    if (shift_i && (cnt_q != '0)) begin
      sreg_d = sreg_q << 1;
      cnt_d  = cnt_q - 1'b1;
    end

    // Refill on the same edge the last bit leaves, so shifting never bubbles.
    reload = buf_full_q && (cnt_d == '0);
    if (reload) begin
      sreg_d     = buf_q;
      cnt_d      = SC_W'(WORD_W);
      buf_full_d = 1'b0;
    end

    if (word_valid_i) begin
      buf_d      = word_data_i;
      buf_full_d = 1'b1;
    end

    if (clear_i) begin
      buf_d      = '0;
      buf_full_d = 1'b0;
      sreg_d     = '0;
      cnt_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      sreg_q     <= '0;
      cnt_q      <= '0;
    end else begin
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      sreg_q     <= sreg_d;
      cnt_q      <= cnt_d;
    end
  end

  assign buf_full_o  = buf_full_q;
  assign bit_o       = sreg_q[WORD_W-1];
  assign bit_avail_o = (cnt_q != '0);
  assign last_bit_o  = (cnt_q == SC_W'(1));

endmodule

// File: rtl/ccff_chain_loader.sv
// Writer end of a ccff configuration chain: serialises config words into ccff_head
// and packs the old configuration leaving ccff_tail into readback words.
module ccff_chain_loader
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = 32,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic               prog_clk,
  input  logic               prog_reset_n,
  input  logic               start,
  ccff_chain_loader_if.slave cfg,
  output logic               ccff_head,
  output logic               chain_clk_en,
  input  logic               ccff_tail,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   bit_count,
  output ccff_dbg_t          dbg
);

  localparam int N_WORDS = ceil_div(CHAIN_LEN, WORD_W);
  localparam int PK_W    = $clog2(WORD_W);

  ccff_state_e       state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  words_q, words_d;
  logic              en_q, en_d;
  logic              head_q, head_d;
  logic              last_q, last_d;
  logic [WORD_W-1:0] pack_q, pack_d;
  logic [PK_W-1:0]   pack_idx_q, pack_idx_d;
  logic [WORD_W-1:0] rb_data_q, rb_data_d;
  logic              rb_valid_q, rb_valid_d;

  logic accept, issue, clear, cfg_ready;
  logic ser_buf_full, ser_bit, ser_bit_avail, ser_last_bit;

  assign cfg_ready = busy && !ser_buf_full && (words_q < CNT_W'(N_WORDS));
  assign accept    = cfg.cfg_valid && cfg_ready;
  assign issue     = (state_q == ST_SHIFT) && ser_bit_avail;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    words_d    = words_q;
    en_d       = 1'b0;
    head_d     = head_q;
    last_d     = 1'b0;
    pack_d     = pack_q;
    pack_idx_d = pack_idx_q;
    rb_data_d  = rb_data_q;
    rb_valid_d = 1'b0;
    clear      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_SHIFT;
          bit_cnt_d  = '0;
          words_d    = '0;
          clear      = 1'b1;
          pack_d     = '0;
          pack_idx_d = '0;
        end
      end
      ST_SHIFT: begin
        // The chain bit is registered; the fabric shifts it on the following edge.
        if (issue) begin
          en_d      = 1'b1;
          head_d    = ser_bit;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
            last_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (accept) words_d = words_q + 1'b1;

    // Capture the bit leaving the chain on every edge the fabric actually shifts.
    if (en_q) begin
      pack_d[PK_W'(WORD_W - 1) - pack_idx_q] = ccff_tail;
      if (last_q || (pack_idx_q == PK_W'(WORD_W - 1))) begin
        rb_data_d  = pack_d;
        rb_valid_d = 1'b1;
        pack_d     = '0;
        pack_idx_d = '0;
      end else begin
        pack_idx_d = pack_idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      words_q    <= '0;
      en_q       <= 1'b0;
      head_q     <= 1'b0;
      last_q     <= 1'b0;
      pack_q     <= '0;
      pack_idx_q <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      words_q    <= words_d;
      en_q       <= en_d;
      head_q     <= head_d;
      last_q     <= last_d;
      pack_q     <= pack_d;
      pack_idx_q <= pack_idx_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  ccff_bit_serializer #(.WORD_W(WORD_W)) u_ser (
    .clk          (prog_clk),
    .rst_n        (prog_reset_n),
    .clear_i      (clear),
    .word_valid_i (accept),
    .word_data_i  (cfg.cfg_data),
    .shift_i      (issue),
    .buf_full_o   (ser_buf_full),
    .bit_o        (ser_bit),
    .bit_avail_o  (ser_bit_avail),
    .last_bit_o   (ser_last_bit)
  );

  assign cfg.cfg_ready = cfg_ready;
  assign cfg.rb_data   = rb_data_q;
  assign cfg.rb_valid  = rb_valid_q;
  assign ccff_head     = head_q;
  assign chain_clk_en  = en_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign bit_count     = bit_cnt_q;
  assign dbg           = '{state: state_q, buf_full: ser_buf_full,
                           bit_avail: ser_bit_avail, last_bit: ser_last_bit};

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a 32-bit and a 20-bit chain, each driven by a
// fabric model that shifts on chain_clk_en, checked against word-level expectations.
module tb_ccff_chain_loader;
  import ccff_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: 32-bit chain ----------------
  ccff_chain_loader_if #(.WORD_W(8)) if_a ();
  logic start_a = 1'b0, head_a, en_a, tail_a, busy_a, done_a;
  logic [5:0] cnt_a;
  ccff_dbg_t dbg_a;
  logic [31:0] chain_a = '0;

  ccff_chain_loader #(.CHAIN_LEN(32), .WORD_W(8)) dut_a (
    .prog_clk(clk), .prog_reset_n(rst_n), .start(start_a), .cfg(if_a),
    .ccff_head(head_a), .chain_clk_en(en_a), .ccff_tail(tail_a),
    .busy(busy_a), .done(done_a), .bit_count(cnt_a), .dbg(dbg_a));

  always @(posedge clk) if (en_a) chain_a <= {chain_a[30:0], head_a};
  assign tail_a = chain_a[31];

  // ---------------- DUT B: 20-bit chain ----------------
  ccff_chain_loader_if #(.WORD_W(8)) if_b ();
  logic start_b = 1'b0, head_b, en_b, tail_b, busy_b, done_b;
  logic [4:0] cnt_b;
  ccff_dbg_t dbg_b;
  logic [19:0] chain_b = '0;

  ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) dut_b (
    .prog_clk(clk), .prog_reset_n(rst_n), .start(start_b), .cfg(if_b),
    .ccff_head(head_b), .chain_clk_en(en_b), .ccff_tail(tail_b),
    .busy(busy_b), .done(done_b), .bit_count(cnt_b), .dbg(dbg_b));

  always @(posedge clk) if (en_b) chain_b <= {chain_b[18:0], head_b};
  assign tail_b = chain_b[19];

  // ---------------- monitors ----------------
  int cyc = 0;
  int en_cnt_a = 0, done_cnt_a = 0, acc_cnt_a = 0, first_en_a = 0, last_en_a = 0, mark_a = 0;
  int en_cnt_b = 0, done_cnt_b = 0, acc_cnt_b = 0, first_en_b = 0, last_en_b = 0, mark_b = 0;
  logic [7:0] got_q_a[$];
  logic [7:0] got_q_b[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (en_a) begin
      if (en_cnt_a == mark_a) first_en_a <= cyc;
      last_en_a <= cyc;
      en_cnt_a  <= en_cnt_a + 1;
    end
    if (done_a) done_cnt_a <= done_cnt_a + 1;
    if (if_a.cfg_valid && if_a.cfg_ready) acc_cnt_a <= acc_cnt_a + 1;
    if (if_a.rb_valid) got_q_a.push_back(if_a.rb_data);
  end

  always @(posedge clk) begin
    if (en_b) begin
      if (en_cnt_b == mark_b) first_en_b <= cyc;
      last_en_b <= cyc;
      en_cnt_b  <= en_cnt_b + 1;
    end
    if (done_b) done_cnt_b <= done_cnt_b + 1;
    if (if_b.cfg_valid && if_b.cfg_ready) acc_cnt_b <= acc_cnt_b + 1;
    if (if_b.rb_valid) got_q_b.push_back(if_b.rb_data);
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_q_a[$];
  logic [7:0]  exp_q_b[$];
  int          rd_a = 0, rd_b = 0;
  logic [31:0] exp_prev [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- per-instance accessors ----------------
  function automatic int  len_of (input int i); return (i == 0) ? 32 : 20; endfunction
  function automatic int  nw_of  (input int i); return (i == 0) ? 4 : 3; endfunction
  function automatic int  en_of  (input int i); return (i == 0) ? en_cnt_a : en_cnt_b; endfunction
  function automatic int  done_of(input int i); return (i == 0) ? done_cnt_a : done_cnt_b; endfunction
  function automatic int  acc_of (input int i); return (i == 0) ? acc_cnt_a : acc_cnt_b; endfunction
  function automatic int  span_of(input int i);
    return (i == 0) ? (last_en_a - first_en_a + 1) : (last_en_b - first_en_b + 1);
  endfunction
  function automatic logic ready_of(input int i); return (i == 0) ? if_a.cfg_ready : if_b.cfg_ready; endfunction
  function automatic logic busy_of (input int i); return (i == 0) ? busy_a : busy_b; endfunction
  function automatic logic [31:0] bitcnt_of(input int i);
    return (i == 0) ? 32'(cnt_a) : 32'(cnt_b);
  endfunction
  function automatic logic [31:0] chain_of(input int i);
    return (i == 0) ? chain_a : 32'(chain_b);
  endfunction

  task automatic set_start(input int i, input logic v);
    if (i == 0) start_a = v; else start_b = v;
  endtask

  task automatic set_valid(input int i, input logic v, input logic [7:0] d);
    if (i == 0) begin if_a.cfg_valid = v; if_a.cfg_data = d; end
    else        begin if_b.cfg_valid = v; if_b.cfg_data = d; end
  endtask

  // Old chain content leaves tail-end first, packed MSB-first, last chunk left-aligned.
  task automatic push_rb(input int i, input logic [31:0] prev);
    int l;
    logic [7:0] c;
    l = len_of(i);
    for (int k = 0; k < l; k += 8) begin
      c = '0;
      for (int j = 0; j < 8; j++) if (k + j < l) c[7-j] = prev[l-1-k-j];
      if (i == 0) exp_q_a.push_back(c); else exp_q_b.push_back(c);
    end
  endtask

  task automatic check_rb(input int i, input string tag);
    int got_n;
    logic [7:0] e;
    got_n = (i == 0) ? (got_q_a.size() - rd_a) : (got_q_b.size() - rd_b);
    check({tag, "_rb_count"}, 32'(got_n), 32'((i == 0) ? exp_q_a.size() : exp_q_b.size()));
    if (i == 0) begin
      while (exp_q_a.size() > 0) begin
        e = exp_q_a.pop_front();
        if (rd_a < got_q_a.size()) begin check({tag, "_rb_data"}, 32'(got_q_a[rd_a]), 32'(e)); rd_a++; end
      end
      rd_a = got_q_a.size();
    end else begin
      while (exp_q_b.size() > 0) begin
        e = exp_q_b.pop_front();
        if (rd_b < got_q_b.size()) begin check({tag, "_rb_data"}, 32'(got_q_b[rd_b]), 32'(e)); rd_b++; end
      end
      rd_b = got_q_b.size();
    end
  endtask

  // Drive one word; returns once it has been accepted (or the bound expires).
  task automatic send_word(input int i, input logic [7:0] w, output bit ok);
    ok = 1'b0;
    set_valid(i, 1'b1, w);
    for (int t = 0; t < 300; t++) begin
      if (ready_of(i)) begin ok = 1'b1; break; end
      @(negedge clk);
      set_start(i, 1'b0);
    end
    @(negedge clk);
    set_start(i, 1'b0);
  endtask

  task automatic run_load(input int i, input logic [31:0] words, input int stall_len,
                          input bit mid_start, input bit hold_valid, input bit rand_gaps,
                          input logic [31:0] exp_chain, input string tag);
    int e0, d0, a0, gap, l, nw;
    bit ok, seen;
    l  = len_of(i);
    nw = nw_of(i);
    push_rb(i, exp_prev[i]);
    e0 = en_of(i); d0 = done_of(i); a0 = acc_of(i);
    if (i == 0) mark_a = e0; else mark_b = e0;
    @(negedge clk); set_start(i, 1'b1);
    @(negedge clk); set_start(i, 1'b0);
    for (int w = 0; w < nw; w++) begin
      gap = (w == 2) ? stall_len : 0;
      if (rand_gaps) gap = $urandom_range(0, 6);
      if (gap > 0) begin
        set_valid(i, 1'b0, 8'h00);
        repeat (gap) @(negedge clk);
      end
      if (mid_start && w == 2) set_start(i, 1'b1);
      send_word(i, words[31-8*w -: 8], ok);
      if (!ok) begin errors++; checks++; $display("FAIL %s_accept_timeout word=%0d", tag, w); end
    end
    if (hold_valid) set_valid(i, 1'b1, 8'hEE); else set_valid(i, 1'b0, 8'h00);
    seen = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (done_of(i) != d0) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    if (!seen) begin errors++; checks++; $display("FAIL %s_done_timeout", tag); end
    repeat (4) @(negedge clk);
    set_valid(i, 1'b0, 8'h00);
    check({tag, "_done_pulses"}, 32'(done_of(i) - d0), 32'd1);
    check({tag, "_shifts"},      32'(en_of(i) - e0),   32'(l));
    check({tag, "_accepts"},     32'(acc_of(i) - a0),  32'(nw));
    check({tag, "_bit_count"},   bitcnt_of(i),         32'(l));
    check({tag, "_busy_after"},  32'(busy_of(i)),      32'd0);
    check({tag, "_chain"},       chain_of(i),          exp_chain);
    if (!rand_gaps && stall_len == 0) check({tag, "_span"}, 32'(span_of(i)), 32'(l));
    if (stall_len >= 20) check({tag, "_stall_gap"}, 32'(span_of(i) > l), 32'd1);
    check_rb(i, tag);
    exp_prev[i] = exp_chain;
  endtask

  typedef struct {
    int          inst;
    logic [31:0] words;
    int          stall_len;
    bit          mid_start;
    bit          hold_valid;
    logic [31:0] exp_chain;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [31:0] p, w, exp_c, stream;
    int e0, inst;
    bit seen;

    tbl[0] = '{inst: 0, words: 32'hA53CFF01, stall_len: 0,  mid_start: 0, hold_valid: 0, exp_chain: 32'hA53CFF01};
    tbl[1] = '{inst: 0, words: 32'h00000000, stall_len: 0,  mid_start: 0, hold_valid: 0, exp_chain: 32'h00000000};
    tbl[2] = '{inst: 0, words: 32'hA53CFF01, stall_len: 20, mid_start: 0, hold_valid: 0, exp_chain: 32'hA53CFF01};
    tbl[3] = '{inst: 0, words: 32'h3C3C0FF0, stall_len: 0,  mid_start: 1, hold_valid: 1, exp_chain: 32'h3C3C0FF0};
    tbl[4] = '{inst: 1, words: 32'h12345F00, stall_len: 0,  mid_start: 0, hold_valid: 0, exp_chain: 32'h00012345};
    tbl[5] = '{inst: 1, words: 32'hABCDE700, stall_len: 0,  mid_start: 0, hold_valid: 0, exp_chain: 32'h000ABCDE};
    exp_prev[0] = '0;
    exp_prev[1] = '0;
    if_a.cfg_valid = 1'b0; if_a.cfg_data = '0;
    if_b.cfg_valid = 1'b0; if_b.cfg_data = '0;

    // Reset state
    #12;
    check("rst_ready_a",   32'(if_a.cfg_ready), 32'd0);
    check("rst_en_a",      32'(en_a),           32'd0);
    check("rst_head_a",    32'(head_a),         32'd0);
    check("rst_busy_a",    32'(busy_a),         32'd0);
    check("rst_done_a",    32'(done_a),         32'd0);
    check("rst_rbv_a",     32'(if_a.rb_valid),  32'd0);
    check("rst_rbd_a",     32'(if_a.rb_data),   32'd0);
    check("rst_cnt_a",     32'(cnt_a),          32'd0);
    check("rst_state_a",   32'(dbg_a.state),    32'(ST_IDLE));
    check("rst_state_b",   32'(dbg_b.state),    32'(ST_IDLE));
    check("rst_ready_b",   32'(if_b.cfg_ready), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // A word offered while idle must not be taken
    if_a.cfg_valid = 1'b1; if_a.cfg_data = 8'h77;
    e0 = acc_cnt_a;
    repeat (3) @(negedge clk);
    check("idle_no_accept", 32'(acc_cnt_a - e0), 32'd0);
    if_a.cfg_valid = 1'b0;

    for (int r = 0; r < 6; r++)
      run_load(tbl[r].inst, tbl[r].words, tbl[r].stall_len, tbl[r].mid_start,
               tbl[r].hold_valid, 1'b0, tbl[r].exp_chain, $sformatf("tbl%0d", r));

    // Reset after 10 shifts: chain keeps a partial load, loader drops everything at once
    p      = exp_prev[0];
    stream = 32'h5A5A5A5A;
    exp_q_a.push_back(p[31:24]);
    e0 = en_cnt_a;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    if_a.cfg_valid = 1'b1; if_a.cfg_data = 8'h5A;
    seen = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (en_cnt_a - e0 >= 10) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    if (!seen) begin errors++; checks++; $display("FAIL rst_mid_timeout"); end
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy",  32'(busy_a),         32'd0);
    check("rst_mid_en",    32'(en_a),           32'd0);
    check("rst_mid_ready", 32'(if_a.cfg_ready), 32'd0);
    check("rst_mid_cnt",   32'(cnt_a),          32'd0);
    if_a.cfg_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    exp_c = (p << 10) | (stream >> 22);
    check("rst_mid_shifts", 32'(en_cnt_a - e0), 32'd10);
    check("rst_mid_chain",  chain_a,            exp_c);
    check_rb(0, "rst_mid");
    exp_prev[0] = exp_c;
    run_load(0, 32'hDEADBEEF, 0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, "post_rst");

    // Randomised loads on both chains
    for (int n = 0; n < 10; n++) begin
      inst  = $urandom_range(0, 1);
      w     = $urandom;
      exp_c = (inst == 0) ? w : (w >> 12);
      run_load(inst, w, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
               exp_c, $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1);
  end

endmodule
